// File: rtl/demux1to4_rr_dispatcher.sv
// Dispatches a valid/ready beat stream to one of four consumer channels.
// A one-entry holding register is loaded round-robin (burst-grouped) or by fixed steering.
module demux1to4_rr_dispatcher #(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode,
  input  logic [3:0]    ch_en,
  input  logic [1:0]    in_sel,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy
);

  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state, state_nxt;
  logic          hold_valid;
  logic [DW-1:0] hold_data;
  logic [1:0]    hold_ch;
  logic [1:0]    rr_ptr;
  logic [CW-1:0] beat_cnt;

  logic          drain, blocked, accept, burst_done;
  logic [1:0]    rr_tgt, target, rr_ptr_nxt;
  logic [CW-1:0] cnt_eff, cnt_inc;

  // First enabled channel at or after start, cyclically; returns start if none enabled.
  function automatic logic [1:0] first_en(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] idx;
    first_en = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (mask[idx]) first_en = idx;
    end
  endfunction

  assign hold_valid = (state == FULL);
  assign busy       = hold_valid;
  assign out_valid  = hold_valid ? (4'b0001 << hold_ch) : 4'b0000;
  assign out_data   = hold_data;

  assign drain    = hold_valid & out_ready[hold_ch];
  assign blocked  = ~mode & (ch_en == 4'b0000);
  assign in_ready = ~blocked & (~hold_valid | drain);
  assign accept   = in_valid & in_ready;

  // A skipped pointer position starts a fresh burst on the channel actually chosen.
  assign rr_tgt     = first_en(ch_en, rr_ptr);
  assign cnt_eff    = ch_en[rr_ptr] ? beat_cnt : '0;
  assign cnt_inc    = cnt_eff + CW'(1);
  assign burst_done = (cnt_inc == CW'(BURST));
  assign rr_ptr_nxt = burst_done ? first_en(ch_en, rr_tgt + 2'd1) : rr_tgt;
  assign target     = mode ? in_sel : rr_tgt;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (drain && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      hold_data <= '0;
      hold_ch   <= 2'd0;
      rr_ptr    <= 2'd0;
      beat_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        hold_data <= in_data;
        hold_ch   <= target;
        if (!mode) begin
          beat_cnt <= burst_done ? '0 : cnt_inc;
          rr_ptr   <= rr_ptr_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux1to4_rr_dispatcher.sv
// Bench for demux1to4_rr_dispatcher: directed scenarios plus a randomized run against a queue model.
module tb_demux1to4_rr_dispatcher;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mode;
  logic [3:0]    ch_en;
  logic [1:0]    in_sel;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [3:0]    out_ready;

  logic          in_ready_a, busy_a, in_ready_b, busy_b;
  logic [3:0]    out_valid_a, out_valid_b;
  logic [DW-1:0] out_data_a, out_data_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  demux1to4_rr_dispatcher #(.DW(DW), .BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .ch_en(ch_en), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .busy(busy_a)
  );

  demux1to4_rr_dispatcher #(.DW(DW), .BURST(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .ch_en(ch_en), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .busy(busy_b)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            ch;
  } beat_t;

  function automatic int pick(input logic [3:0] m, input int s);
    for (int i = 0; i < 4; i++) if (m[(s + i) % 4]) return (s + i) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; ch_en = 4'hF;
    in_sel = 2'd0; in_data = '0; out_ready = 4'hF;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    out_ready = 4'h0; in_valid = 1'b1; in_data = 8'h5A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL reset_pre_busy: got %b want 1", busy_a); end
    n_tests++;
    if (out_valid_a !== 4'b0001) begin n_fail++; $display("FAIL reset_pre_valid: got %b want 0001", out_valid_a); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid_a !== 4'b0000) begin n_fail++; $display("FAIL reset_async_valid: got %b want 0000", out_valid_a); end
    n_tests++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_async_busy: got %b want 0", busy_a); end
    n_tests++;
    if (out_data_a !== 8'h00) begin n_fail++; $display("FAIL reset_async_data: got %h want 00", out_data_a); end
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 4'hF; mode = 1'b0; ch_en = 4'hF;
    @(negedge clk);
    n_tests++;
    if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready_a); end
  endtask

  task automatic test_rr_burst();
    logic [3:0] exp_v;
    do_reset();
    mode = 1'b0; ch_en = 4'hF; out_ready = 4'hF;
    for (int i = 0; i <= 16; i++) begin
      in_valid = (i < 16);
      in_data  = 8'(i);
      @(negedge clk);
      if (i < 16) begin
        n_tests++;
        if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL rr_ready beat %0d: got %b want 1", i, in_ready_a); end
      end
      if (i > 0) begin
        exp_v = 4'(1 << ((i - 1) / 4));
        n_tests++;
        if (out_valid_a !== exp_v) begin n_fail++; $display("FAIL rr_valid beat %0d: got %b want %b", i - 1, out_valid_a, exp_v); end
        n_tests++;
        if (out_data_a !== 8'(i - 1)) begin n_fail++; $display("FAIL rr_data beat %0d: got %h want %h", i - 1, out_data_a, 8'(i - 1)); end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_skip();
    logic [DW-1:0] d [3] = '{8'hAA, 8'hBB, 8'hCC};
    int            c [3] = '{1, 3, 1};
    logic [3:0]    exp_v;
    do_reset();
    mode = 1'b0; ch_en = 4'b1010; out_ready = 4'hF;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = d[i];
      @(negedge clk);
      n_tests++;
      if (in_ready_b !== 1'b1) begin n_fail++; $display("FAIL skip_ready beat %0d: got %b want 1", i, in_ready_b); end
      if (i > 0) begin
        exp_v = 4'(1 << c[i - 1]);
        n_tests++;
        if (out_valid_b !== exp_v) begin n_fail++; $display("FAIL skip_valid beat %0d: got %b want %b", i - 1, out_valid_b, exp_v); end
        n_tests++;
        if (out_data_b !== d[i - 1]) begin n_fail++; $display("FAIL skip_data beat %0d: got %h want %h", i - 1, out_data_b, d[i - 1]); end
      end
      @(posedge clk); #1;
    end
    ch_en = 4'b0000; in_valid = 1'b1; in_data = 8'hDD;
    @(negedge clk);
    n_tests++;
    if (out_valid_b !== 4'b0010) begin n_fail++; $display("FAIL skip_c_valid: got %b want 0010", out_valid_b); end
    n_tests++;
    if (out_data_b !== 8'hCC) begin n_fail++; $display("FAIL skip_c_data: got %h want cc", out_data_b); end
    n_tests++;
    if (in_ready_b !== 1'b0) begin n_fail++; $display("FAIL skip_blocked_ready: got %b want 0", in_ready_b); end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (out_valid_b !== 4'b0000) begin n_fail++; $display("FAIL skip_d_dropped: got %b want 0000", out_valid_b); end
    n_tests++;
    if (in_ready_b !== 1'b0) begin n_fail++; $display("FAIL skip_still_blocked: got %b want 0", in_ready_b); end
    n_tests++;
    if (busy_b !== 1'b0) begin n_fail++; $display("FAIL skip_busy: got %b want 0", busy_b); end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    mode = 1'b1; in_sel = 2'd2; out_ready = 4'b1011;
    in_valid = 1'b1; in_data = 8'h11;
    @(posedge clk); #1;
    in_data = 8'h22;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid_a !== 4'b0100) begin n_fail++; $display("FAIL stall_valid cyc %0d: got %b want 0100", k, out_valid_a); end
      n_tests++;
      if (out_data_a !== 8'h11) begin n_fail++; $display("FAIL stall_data cyc %0d: got %h want 11", k, out_data_a); end
      n_tests++;
      if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL stall_ready cyc %0d: got %b want 0", k, in_ready_a); end
      @(posedge clk); #1;
    end
    out_ready = 4'hF;
    @(negedge clk);
    n_tests++;
    if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b want 1", in_ready_a); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_valid_a !== 4'b0100) begin n_fail++; $display("FAIL stall_b2b_valid: got %b want 0100", out_valid_a); end
    n_tests++;
    if (out_data_a !== 8'h22) begin n_fail++; $display("FAIL stall_b2b_data: got %h want 22", out_data_a); end
    @(posedge clk); #1;
  endtask

  task automatic test_mode_switch();
    logic       md [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int         c  [6] = '{0, 0, 3, 0, 0, 1};
    logic [3:0] exp_v;
    do_reset();
    ch_en = 4'hF; out_ready = 4'hF; in_sel = 2'd3;
    for (int i = 0; i <= 6; i++) begin
      in_valid = (i < 6);
      if (i < 6) mode = md[i];
      in_data = 8'(8'h50 + i);
      @(negedge clk);
      if (i > 0) begin
        exp_v = 4'(1 << c[i - 1]);
        n_tests++;
        if (out_valid_a !== exp_v) begin n_fail++; $display("FAIL mode_valid beat %0d: got %b want %b", i - 1, out_valid_a, exp_v); end
        n_tests++;
        if (out_data_a !== 8'(8'h50 + i - 1)) begin n_fail++; $display("FAIL mode_data beat %0d: got %h want %h", i - 1, out_data_a, 8'(8'h50 + i - 1)); end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; mode = 1'b0;
  endtask

  task automatic test_random();
    beat_t      q[$];
    beat_t      b;
    int         ptr, cnt, t, delivered;
    logic       exp_ready, drain, acc;
    logic [3:0] exp_v;
    do_reset();
    ptr = 0; cnt = 0; delivered = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      in_sel    = 2'($urandom);
      out_ready = 4'($urandom);
      if ($urandom_range(0, 7) == 0) ch_en = 4'($urandom);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      @(negedge clk);
      exp_ready = !((mode == 1'b0) && (ch_en == 4'b0000)) &&
                  ((q.size() == 0) || out_ready[q[0].ch]);
      exp_v = (q.size() != 0) ? 4'(1 << q[0].ch) : 4'b0000;
      n_tests++;
      if (in_ready_a !== exp_ready) begin n_fail++; $display("FAIL rnd_ready cyc %0d: got %b want %b", cyc, in_ready_a, exp_ready); end
      n_tests++;
      if (out_valid_a !== exp_v) begin n_fail++; $display("FAIL rnd_valid cyc %0d: got %b want %b", cyc, out_valid_a, exp_v); end
      n_tests++;
      if ($countones(out_valid_a) > 1) begin n_fail++; $display("FAIL rnd_onehot cyc %0d: got %b want at most one bit", cyc, out_valid_a); end
      n_tests++;
      if (busy_a !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_busy cyc %0d: got %b want %b", cyc, busy_a, q.size() != 0); end
      if (q.size() != 0) begin
        n_tests++;
        if (out_data_a !== q[0].d) begin n_fail++; $display("FAIL rnd_data cyc %0d: got %h want %h", cyc, out_data_a, q[0].d); end
      end
      drain = (q.size() != 0) && out_ready[q[0].ch];
      acc   = in_valid && exp_ready;
      if (drain) begin
        void'(q.pop_front());
        delivered++;
      end
      if (acc) begin
        if (mode) begin
          t = int'(in_sel);
        end else begin
          t = pick(ch_en, ptr);
          if (t != ptr) cnt = 0;
          cnt++;
          if (cnt == 4) begin
            cnt = 0;
            ptr = pick(ch_en, t + 1);
          end else begin
            ptr = t;
          end
        end
        b.d = in_data; b.ch = t;
        q.push_back(b);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_tests++;
    if (delivered < 1000) begin n_fail++; $display("FAIL rnd_delivered: got %0d want at least 1000", delivered); end
  endtask

  initial begin
    test_reset();
    test_rr_burst();
    test_skip();
    test_stall();
    test_mode_switch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
